// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process a
// WIDTH-bit operand pair LSB-first, with accumulate mode and start/busy/done handshake.
module serial_adder #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             maj_s;

  // The single full-adder cell shared by every bit position.
  assign bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign maj_s = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    shr_d   = shr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          opa_d   = acc ? sum_q : a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        carry_d = maj_s;
        shr_d   = {bit_s, shr_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is still the carry into the MSB on this cycle.
          state_d = S_DONE;
          sum_d   = {bit_s, shr_q[WIDTH-1:1]};
          cout_d  = maj_s;
          ovf_d   = carry_q ^ maj_s;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too; sum feeds back in accumulate
      // mode and must never start from an unknown value.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      shr_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      shr_q   <= shr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a word-level reference model pushes expected
// results to a scoreboard, popped and compared on each done pulse.
module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  result_t          sb_q[$];
  logic [WIDTH-1:0] model_sum;
  int               n_checks;
  int               n_pass;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .acc   (acc),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Word-level reference: full-width add with explicit carry and sign rules.
  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic si, input logic acci);
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0]   full;
    result_t          r;
    opa  = acci ? model_sum : ai;
    opb  = si ? ~bi : bi;
    full = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, si};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (opa[WIDTH-1] == opb[WIDTH-1]) && (r.sum[WIDTH-1] != opa[WIDTH-1]);
    model_sum = r.sum;
    sb_q.push_back(r);
    a = ai; b = bi; sub = si; acc = acci; start = 1'b1;
  endtask

  task automatic watch_run(input string tag, input bit drop_start);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (drop_start) start = 1'b0;
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
    end
  endtask

  task automatic watch_done(input string tag);
    result_t r;
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_notbusy"}, busy, 1'b0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      r = sb_q.pop_front();
      check({tag, "_sum"}, sum, r.sum);
      check({tag, "_cout"}, cout, r.cout);
      check({tag, "_ovf"}, ovf, r.ovf);
    end
  endtask

  task automatic watch_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic single_op(input string tag, input logic [WIDTH-1:0] ai,
                           input logic [WIDTH-1:0] bi, input logic si);
    @(negedge clk);
    issue(ai, bi, si, 1'b0);
    watch_run(tag, 1'b1);
    watch_done(tag);
    watch_idle(tag);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; model_sum = '0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; acc = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    watch_idle("post_rst");

    single_op("add_3c_25", 8'h3C, 8'h25, 1'b0);
    single_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    single_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
    single_op("sub_10_20", 8'h10, 8'h20, 1'b1);
    single_op("sub_80_01", 8'h80, 8'h01, 1'b1);
    single_op("add_05_00", 8'h05, 8'h00, 1'b0);

    // Accumulate twice with start held high straight through DONE.
    @(negedge clk);
    issue(8'h00, 8'h05, 1'b0, 1'b1);
    issue(8'h00, 8'h05, 1'b0, 1'b1);
    watch_run("acc1", 1'b0);
    watch_done("acc1");
    watch_run("acc2", 1'b0);
    watch_done("acc2");
    start = 1'b0;
    watch_idle("acc2");

    // Inputs churn during RUN; the captured operands must win.
    @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      start = (i >= 2 && i <= 4);
      a = 8'hFF; b = 8'hFF; sub = 1'b1; acc = 1'b1;
      check("churn_busy", busy, 1'b1);
      check("churn_nodone", done, 1'b0);
    end
    watch_done("churn");
    watch_idle("churn");

    // Reset during the fourth RUN cycle aborts the operation.
    @(negedge clk);
    issue(8'h55, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_busy", busy, 1'b1);
    end
    @(negedge clk);
    check("abort_run4_busy", busy, 1'b1);
    rst_n = 1'b0;
    sb_q.delete();
    model_sum = '0;
    @(negedge clk);
    check("abort_busy_low", busy, 1'b0);
    check("abort_done_low", done, 1'b0);
    check("abort_sum", sum, '0);
    check("abort_cout", cout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) watch_idle("abort_quiet");

    single_op("add_01_01", 8'h01, 8'h01, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that reuses one full-adder cell and a carry flip-flop to process a WIDTH-bit operand pair LSB-first, one bit per clock. It generalises the board's combinational 4-bit ripple adder to arbitrary width and adds subtract and accumulate modes, a start/busy/done handshake, and carry and overflow flags. It sits between the switch/key input logic and the LED/segment display logic on the lab board.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the internal bit counter; derived, not overridden.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- acc  in  1  1 = use the current sum register as operand A instead of port a; sampled with start.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- busy  out  1  high while the operation is in progress.
- done  out  1  single-cycle pulse when the result is valid.
- sum  out  WIDTH  result; holds the last completed result.
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow, i.e. A ≥ B unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1: latch opA = acc ? sum : a, and opB = sub ? ~b : b. Set carry = sub, counter = 0, then go to RUN. start=0: stay in IDLE.
- RUN, each cycle:
  - bit = opA[0]^opB[0]^carry.
  - carry ← majority(opA[0], opB[0], carry).
  - Shift bit into the MSB of the internal result shift register (right shift); shift opA and opB right.
  - counter++.
  - On the cycle with counter == WIDTH−1, also record the carry into the MSB (the carry value before the update) for ovf.
- After WIDTH RUN cycles go to DONE. On that edge: sum ← shift register, cout ← final carry, ovf ← carry-in-MSB ^ final carry.
- DONE lasts one cycle, with done=1. If start=1 in DONE, the operation is accepted exactly as in IDLE (back-to-back, goes to RUN); otherwise go to IDLE.
- start, sub, acc, a and b are ignored in RUN. Operands are captured, so input changes during RUN do not affect the result.
- sum, cout and ovf change only on the DONE-entry edge or on reset; they never show partial results.
- All arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. State = IDLE, counter = 0, carry = 0.
- Reset asserted mid-operation aborts it: outputs go to reset values on the next edge, and no done pulse is produced.
- start sampled at edge k:
  - busy=1 after edges k..k+WIDTH−1 (WIDTH cycles).
  - On edge k+WIDTH: done=1, busy=0, and the result is valid.
  - Latency from start to done is WIDTH cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles (start held high continuously).
- busy and done are never high in the same cycle.

## Test plan
- WIDTH=8, a=0x3C, b=0x25, sub=0, start for 1 cycle -> done exactly 8 cycles later; sum=0x61, cout=0, ovf=0; busy high for 8 cycles.
- a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1: a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- After a=0x05+b=0x00, issue acc=1, b=0x05 twice, with start held high through DONE -> sums 0x0A then 0x0F; no idle cycle between operations; each done pulse is 1 cycle.
- start re-asserted and a/b changed during RUN -> ignored; result matches the originally captured operands; only one done pulse.
- rst_n low at the 4th RUN cycle -> next edge: busy=0, sum=0, no done. Releasing reset and starting 0x01+0x01 -> sum=0x02 after 8 cycles.
